uart_tx_perip: RTL and testbench

UART_TX_PERIP -- requirements
Module: uart_tx_perip

---
 rtl/uart_tx_perip.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_perip.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_perip.sv
`default_nettype none
// ============================================================================
// uart_tx_perip : UART transmitter fed from a memory-mapped register file
// (CTRL / DIV / TXDATA / STATUS words).
// Revision: 1.0
// ============================================================================
module uart_tx_perip #(
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
  parameter logic [31:0] DIV_ADDR  = 32'h0000_0004,
  parameter logic [31:0] DATA_ADDR = 32'h0000_0008,
  parameter logic [31:0] STAT_ADDR = 32'h0000_000C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] rdaddr_perip,
  input  logic [31:0] data_o_perip,
  output logic        write_perip,
  output logic [31:0] wraddr_perip,
  output logic [31:0] data_i_perip,
  output logic        tx_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_DIV    = 4'd1,
    ST_RD_DATA   = 4'd2,
    ST_CLR_START = 4'd3,
    ST_SET_BUSY  = 4'd4,
    ST_START     = 4'd5,
    ST_DATA      = 4'd6,
    ST_STOP      = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  state_t      state_q;
  logic [15:0] period_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [31:0] rdaddr_q;
  logic [31:0] wraddr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        tx_q;
  logic        busy_q;

  logic [15:0] period_d;
  logic        cnt_zero_d;
  logic        unused_rd_bits;

  // A zero divisor would never let the bit counter expire, so it is clamped to 1.
  assign period_d       = (data_o_perip[15:0] == 16'd0) ? 16'd1 : data_o_perip[15:0];
  assign cnt_zero_d     = (cnt_q == 16'd0);
  assign unused_rd_bits = ^data_o_perip[31:16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      period_q  <= 16'd0;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      rdaddr_q  <= CTRL_ADDR;
      wraddr_q  <= 32'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_o_perip[0]) begin
            state_q  <= ST_RD_DIV;
            rdaddr_q <= DIV_ADDR;
          end
        end
        ST_RD_DIV: begin
          period_q <= period_d;
          state_q  <= ST_RD_DATA;
          rdaddr_q <= DATA_ADDR;
        end
        ST_RD_DATA: begin
          shift_q  <= data_o_perip[7:0];
          state_q  <= ST_CLR_START;
          rdaddr_q <= CTRL_ADDR;
          write_q  <= 1'b1;
          wraddr_q <= CTRL_ADDR;
          wdata_q  <= 32'd0;
        end
        ST_CLR_START: begin
          state_q  <= ST_SET_BUSY;
          wraddr_q <= STAT_ADDR;
          wdata_q  <= 32'h1;
          busy_q   <= 1'b1;
        end
        ST_SET_BUSY: begin
          state_q  <= ST_START;
          write_q  <= 1'b0;
          wraddr_q <= 32'd0;
          wdata_q  <= 32'd0;
          tx_q     <= 1'b0;
          cnt_q    <= period_q - 16'd1;
        end
        ST_START: begin
          if (cnt_zero_d) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= 3'd0;
            cnt_q     <= period_q - 16'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_zero_d) begin
            cnt_q <= period_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              // Next bit is presented from shift_q[1] as the register shifts.
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_zero_d) begin
            state_q  <= ST_DONE;
            write_q  <= 1'b1;
            wraddr_q <= STAT_ADDR;
            wdata_q  <= 32'h2;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          write_q  <= 1'b0;
          wraddr_q <= 32'd0;
          wdata_q  <= 32'd0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          rdaddr_q <= CTRL_ADDR;
          write_q  <= 1'b0;
          wraddr_q <= 32'd0;
          wdata_q  <= 32'd0;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdaddr_perip = rdaddr_q;
  assign write_perip  = write_q;
  assign wraddr_perip = wraddr_q;
  assign data_i_perip = wdata_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_perip.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_perip : directed bench with register-file model and scoreboards.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_perip;

  localparam logic [31:0] CTRL_A = 32'h0000_0000;
  localparam logic [31:0] DIV_A  = 32'h0000_0004;
  localparam logic [31:0] DATA_A = 32'h0000_0008;
  localparam logic [31:0] STAT_A = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rdaddr_perip;
  logic [31:0] data_o_perip;
  logic        write_perip;
  logic [31:0] wraddr_perip;
  logic [31:0] data_i_perip;
  logic        tx_o;
  logic        busy_o;

  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_data = 32'd0;
  logic [31:0] rf [0:3];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_count = 0;
  int last_clr_cyc = 0;
  int busy_run = 0;

  logic [63:0] exp_wr_q [$];
  logic [23:0] exp_fr_q [$];
  int          frame_starts [$];
  int          done_cycs [$];
  int          busy_lens [$];

  uart_tx_perip dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rdaddr_perip (rdaddr_perip),
    .data_o_perip (data_o_perip),
    .write_perip  (write_perip),
    .wraddr_perip (wraddr_perip),
    .data_i_perip (data_i_perip),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: the external bus write lands after the DUT write, so it wins.
  always @(posedge clk) begin
    if (write_perip) rf[wraddr_perip[3:2]] <= data_i_perip;
    if (bus_we)      rf[bus_addr[3:2]]     <= bus_data;
  end
  assign data_o_perip = rf[rdaddr_perip[3:2]];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and bus-idle checks.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (write_perip === 1'b1) begin
        wr_count++;
        chk("write_expected", exp_wr_q.size() != 0, 1);
        if (exp_wr_q.size() != 0)
          chk("write_addr_data", {wraddr_perip, data_i_perip}, exp_wr_q.pop_front());
        chk("busy_at_write", busy_o, wraddr_perip == STAT_A);
        chk("rdaddr_at_write", rdaddr_perip, CTRL_A);
        if (wraddr_perip == CTRL_A) last_clr_cyc = cyc;
        if (wraddr_perip == STAT_A && data_i_perip == 32'h2) done_cycs.push_back(cyc);
      end else begin
        chk("idle_bus_zero", {wraddr_perip, data_i_perip}, 65'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) busy_run = 0;
    else if (busy_o === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      busy_lens.push_back(busy_run);
      busy_run = 0;
    end
  end

  // Frame scoreboard: each bit must hold its value for exactly P samples.
  initial begin : frame_mon
    logic [23:0] e;
    logic [9:0]  bits;
    int          errs;
    int          p;
    bit          ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
        frame_starts.push_back(cyc);
        chk("start_latency", cyc, last_clr_cyc + 2);
        chk("frame_expected", exp_fr_q.size() != 0, 1);
        if (exp_fr_q.size() != 0) begin
          e    = exp_fr_q.pop_front();
          p    = (e[23:8] == 16'd0) ? 1 : int'(e[23:8]);
          bits = {1'b1, e[7:0], 1'b0};
          ab   = 1'b0;
          for (int i = 0; i < 10 && !ab; i++) begin
            errs = 0;
            for (int j = 0; j < p && !ab; j++) begin
              if (i != 0 || j != 0) begin
                @(negedge clk);
                if (rst_n !== 1'b1) ab = 1'b1;
              end
              if (!ab && tx_o !== bits[i]) errs++;
            end
            if (!ab) chk($sformatf("frame_bit%0d", i), errs, 0);
          end
          if (!ab) begin
            @(negedge clk);
            if (rst_n === 1'b1)
              chk("done_after_stop", {write_perip, wraddr_perip, data_i_perip}, {1'b1, STAT_A, 32'h2});
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a;
    bus_data = d;
    bus_we   = 1'b1;
    @(negedge clk);
    bus_we   = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] div, input logic [7:0] b, input bit full);
    exp_fr_q.push_back({div, b});
    exp_wr_q.push_back({CTRL_A, 32'h0});
    exp_wr_q.push_back({STAT_A, 32'h1});
    if (full) exp_wr_q.push_back({STAT_A, 32'h2});
  endtask

  task automatic start_frame(input logic [15:0] div, input logic [7:0] b, input bit full);
    bus_write(DIV_A, {16'h0, div});
    bus_write(DATA_A, {24'h0, b});
    push_exp(div, b, full);
    bus_write(CTRL_A, 32'h1);
  endtask

  task automatic wait_wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    int k = 0;
    while (!(write_perip === 1'b1 && wraddr_perip === a && data_i_perip === d) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k < 200, 1);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int k = 0;
    while ((exp_wr_q.size() != 0 || exp_fr_q.size() != 0 || busy_o !== 1'b0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k < bound, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_high", tx_o, 1);
    chk("rst_write_low", write_perip, 0);
    chk("rst_busy_low", busy_o, 0);
    chk("rst_rdaddr", rdaddr_perip, CTRL_A);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_wr_q.delete();
    exp_fr_q.delete();
  endtask

  initial begin : stim
    int n0;
    int nd;
    int nf;
    int highs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus_write(CTRL_A, 32'h0);
    bus_write(DIV_A,  32'h0);
    bus_write(DATA_A, 32'h0);
    bus_write(STAT_A, 32'h0);

    chk("reset_tx", tx_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_write", write_perip, 0);
    chk("reset_wraddr", wraddr_perip, 0);
    chk("reset_wdata", data_i_perip, 0);
    chk("reset_rdaddr", rdaddr_perip, CTRL_A);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_write", wr_count, 0);

    // Nominal frame, P=4, 0xA5.
    start_frame(16'd4, 8'hA5, 1'b1);
    wait_drain(200, "drain_a5");
    chk("stat_after_a5", rf[3], 32'h2);
    chk("ctrl_after_a5", rf[0], 32'h0);
    chk("busy_len_a5", busy_lens[busy_lens.size()-1], 42);

    // Zero divisor clamps to one cycle per bit.
    start_frame(16'd0, 8'h00, 1'b1);
    wait_drain(100, "drain_p1");
    chk("busy_len_p1", busy_lens[busy_lens.size()-1], 12);

    start_frame(16'd2, 8'hFF, 1'b1);
    wait_drain(100, "drain_ff");

    // Divisor above 8 bits.
    start_frame(16'h0101, 8'h5A, 1'b1);
    wait_drain(3000, "drain_257");

    // Back-to-back: CTRL re-armed during STOP, TXDATA changed mid-frame.
    start_frame(16'd2, 8'h33, 1'b1);
    wait_wr(STAT_A, 32'h1, "b2b_set_busy");
    bus_write(DATA_A, 32'hC3);
    push_exp(16'd2, 8'hC3, 1'b1);
    repeat (18) @(negedge clk);
    bus_write(CTRL_A, 32'h1);
    wait_drain(200, "drain_b2b");
    nd = done_cycs.size();
    nf = frame_starts.size();
    chk("b2b_gap", frame_starts[nf-1] - done_cycs[nd-2], 6);

    // Bus re-arms CTRL in the very cycle the DUT clears it.
    n0 = frame_starts.size();
    start_frame(16'd3, 8'h96, 1'b1);
    push_exp(16'd2, 8'h4B, 1'b1);
    wait_wr(CTRL_A, 32'h0, "coll_clr_seen");
    bus_write(CTRL_A, 32'h1);
    bus_write(DIV_A,  32'h2);
    bus_write(DATA_A, 32'h4B);
    wait_drain(300, "drain_coll");
    repeat (20) @(negedge clk);
    chk("coll_two_frames", frame_starts.size() - n0, 2);
    chk("coll_ctrl_clear", rf[0], 32'h0);

    // Reset in the middle of data bit 3.
    start_frame(16'd4, 8'hA5, 1'b0);
    wait_wr(STAT_A, 32'h1, "rst_set_busy");
    repeat (19) @(negedge clk);
    chk("midbit3_tx", tx_o, 0);
    pulse_reset();
    n0 = wr_count;
    repeat (30) @(negedge clk);
    chk("no_write_after_rst", wr_count, n0);
    chk("idle_tx_after_rst", tx_o, 1);

    // Maximum divisor: line must stay low well past any truncated count.
    start_frame(16'hFFFF, 8'h80, 1'b0);
    wait_wr(STAT_A, 32'h1, "max_set_busy");
    highs = 0;
    repeat (20000) begin
      @(negedge clk);
      if (tx_o !== 1'b0) highs++;
    end
    chk("max_div_low", highs, 0);
    chk("max_div_busy", busy_o, 1);
    pulse_reset();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
